mips_issue_queue: RTL and testbench

MIPS_ISSUE_QUEUE -- requirements
Module: mips_issue_queue

---
 rtl/mips_pkg.sv | 20 ++
 rtl/issue_fifo.sv | 56 +++++
 rtl/mips_issue_queue.sv | 91 +++++++++
 tb/tb_mips_issue_queue.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS issue queue: controller states and
// the instruction/output-register field widths that make up one queue entry.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OREG_W  = 20;
  localparam int ENTRY_W = INSTR_W + OREG_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [OREG_W-1:0]  oreg;
  } entry_t;

endpackage

// File: rtl/issue_fifo.sv
// Circular buffer holding queued instruction entries; pointers wrap naturally
// because DEPTH is a power of two.
module issue_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 52,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; count and pointers alone decide which slots are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments with the reset folded into the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mips_issue_queue.sv
// Buffers instructions and feeds them one at a time to a MIPS core, waiting
// for each completion pulse before issuing the next entry.
module mips_issue_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [INSTR_W-1:0]           instruction,
  input  logic [OREG_W-1:0]            output_reg,
  output logic                         in_ready,
  output logic                         issue_valid,
  output logic [INSTR_W-1:0]           issue_instruction,
  output logic [OREG_W-1:0]            issue_output_reg,
  input  logic                         mips_out_valid,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  state_t state;
  state_t state_next;
  entry_t head;
  entry_t wentry;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  assign wentry   = '{instr: instruction, oreg: output_reg};
  assign in_ready = !fifo_full;

  issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid && in_ready),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_next = ISSUE;
          pop        = 1'b1;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (mips_out_valid) begin
          if (!fifo_empty) begin
            state_next = ISSUE;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state             <= IDLE;
      issue_instruction <= '0;
      issue_output_reg  <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        issue_instruction <= head.instr;
        issue_output_reg  <= head.oreg;
      end
    end
  end

  assign issue_valid = (state == ISSUE);
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mips_issue_queue.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// against a queue-based reference model of the issue controller.
module tb_mips_issue_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] i;
    logic [19:0] o;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [31:0]      instruction;
  logic [19:0]      output_reg;
  logic             in_ready;
  logic             issue_valid;
  logic [31:0]      issue_instruction;
  logic [19:0]      issue_output_reg;
  logic             mips_out_valid;
  logic             busy;
  logic [CNT_W-1:0] count;

  mips_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .instruction       (instruction),
    .output_reg        (output_reg),
    .in_ready          (in_ready),
    .issue_valid       (issue_valid),
    .issue_instruction (issue_instruction),
    .issue_output_reg  (issue_output_reg),
    .mips_out_valid    (mips_out_valid),
    .busy              (busy),
    .count             (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: pending entries, an instruction outstanding in the core,
  // whether this cycle is the issue pulse, and the last issued entry.
  ent_t        q[$];
  bit          m_out;
  bit          m_iss;
  logic [31:0] m_instr;
  logic [19:0] m_oreg;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit iv, input logic [31:0] ins,
                            input logic [19:0] oreg, input bit mov);
    bit   accept;
    bit   done;
    bit   take;
    ent_t e;
    if (!rst) begin
      q.delete();
      m_out   = 0;
      m_iss   = 0;
      m_instr = '0;
      m_oreg  = '0;
    end else begin
      accept = iv && (q.size() < DEPTH);
      done   = m_out && !m_iss && mov;
      take   = (q.size() != 0) && (!m_out || done);
      if (take) begin
        e       = q.pop_front();
        m_instr = e.i;
        m_oreg  = e.o;
      end
      if (accept) q.push_back('{i: ins, o: oreg});
      m_iss = take;
      m_out = take ? 1'b1 : (done ? 1'b0 : m_out);
    end
  endtask

  task automatic compare_all();
    check("issue_valid", 64'(issue_valid), 64'(m_iss));
    check("busy", 64'(busy), 64'(m_out));
    check("count", 64'(count), 64'(q.size()));
    check("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    check("issue_instruction", 64'(issue_instruction), 64'(m_instr));
    check("issue_output_reg", 64'(issue_output_reg), 64'(m_oreg));
  endtask

  // One clock cycle: drive inputs, let the edge happen, then compare mid-cycle.
  task automatic step(input bit rst, input bit iv, input logic [31:0] ins,
                      input logic [19:0] oreg, input bit mov);
    rst_n          = rst;
    in_valid       = iv;
    instruction    = ins;
    output_reg     = oreg;
    mips_out_valid = mov;
    @(posedge clk);
    model_edge(rst, iv, ins, oreg, mov);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 0, '0, '0, 0);
  endtask

  task automatic push(input logic [31:0] ins, input logic [19:0] oreg);
    step(1, 1, ins, oreg, 0);
  endtask

  task automatic complete();
    step(1, 0, '0, '0, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    instruction    = '0;
    output_reg     = '0;
    mips_out_valid = 1'b0;

    // Reset state
    step(0, 0, '0, '0, 0);
    step(0, 1, 32'hDEAD_BEEF, 20'h12345, 1);

    // Single push: issue two cycles later, busy until after completion
    push(32'h0231_8020, 20'h8C8D1);
    idle(1);
    check("s1_issue_valid", 64'(issue_valid), 64'd1);
    check("s1_issue_instr", 64'(issue_instruction), 64'h0231_8020);
    check("s1_issue_oreg", 64'(issue_output_reg), 64'h8C8D1);
    idle(3);
    complete();
    idle(2);
    check("s1_busy_after", 64'(busy), 64'd0);

    // Completion pulses in IDLE are ignored
    for (int k = 0; k < 3; k++) complete();

    // Fill the queue while the core is busy, fifth push dropped
    push(32'h1111_0000, 20'h00001);
    idle(3);
    push(32'hAAAA_0001, 20'hA0001);
    push(32'hBBBB_0002, 20'hB0002);
    push(32'hCCCC_0003, 20'hC0003);
    push(32'hDDDD_0004, 20'hD0004);
    push(32'hEEEE_0005, 20'hE0005);
    check("s2_count_full", 64'(count), 64'd4);
    check("s2_in_ready", 64'(in_ready), 64'd0);

    // Completion while full with in_valid held: next push accepted after the pop
    step(1, 1, 32'hFFFF_0006, 20'hF0006, 1);
    check("s3_count_after_pop", 64'(count), 64'd3);
    step(1, 1, 32'hFFFF_0006, 20'hF0006, 0);
    check("s3_count_refill", 64'(count), 64'd4);
    for (int k = 0; k < 6; k++) begin
      idle(2);
      complete();
    end
    idle(2);
    check("s3_drained", 64'(count), 64'd0);

    // Reset during WAIT with entries queued, then normal latency again
    push(32'h2222_0000, 20'h22222);
    idle(2);
    push(32'h3333_0001, 20'h33331);
    push(32'h3333_0002, 20'h33332);
    push(32'h3333_0003, 20'h33333);
    step(0, 0, '0, '0, 0);
    check("s4_count_reset", 64'(count), 64'd0);
    check("s4_busy_reset", 64'(busy), 64'd0);
    idle(1);
    check("s4_no_issue", 64'(issue_valid), 64'd0);
    push(32'h4444_0000, 20'h44444);
    idle(1);
    check("s4_relaunch", 64'(issue_valid), 64'd1);
    idle(1);
    complete();

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 1) == 1),
           $urandom(),
           20'($urandom()),
           ($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
